// File: rtl/key_scan_pkg.sv
// Shared types and constants for the key_scan debouncer.
// Filter FSM state encoding and synchroniser depth.
package key_scan_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } key_fsm_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/key_filter.sv
// One key channel: two-flop synchroniser, debounce FSM, registered press/release pulses.
// Define KEY_LONG_PRESS_EN to add the per-channel long-press hold counter.
module key_filter #(
  parameter int unsigned TIME_20MS = 1_000_000,
  parameter int unsigned TIME_LONG = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  import key_scan_pkg::*;

  localparam int CNT_W = (TIME_20MS > 2) ? $clog2(TIME_20MS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIME_20MS - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  key_fsm_e              state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;
  logic                  key_sync;

  // Raw pin is active-low; the FSM only ever looks at the last synchroniser stage.
  assign key_sync = sync_q[SYNC_DEPTH-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_DEPTH-2:0], key_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = FILTER_DOWN;
          cnt_d   = '0;
        end
      end
      FILTER_DOWN: begin
        if (key_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DOWN;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (key_sync) begin
          state_d = FILTER_UP;
          cnt_d   = '0;
        end
      end
      FILTER_UP: begin
        if (!key_sync) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int HOLD_W = (TIME_LONG > 2) ? $clog2(TIME_LONG) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIME_LONG - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Hold count survives a FILTER_UP bounce and saturates so each hold pulses once.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == FILTER_DOWN && state_d == DOWN) begin
      hold_d = '0;
    end else if (state_q == DOWN && state_d == DOWN && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_d == HOLD_MAX);
    end else if (state_d == IDLE) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Debounced active-low push-button scanner: one independent key_filter per channel.
// Optional long-press pulses are enabled with KEY_LONG_PRESS_EN.
module key_scan #(
  parameter int unsigned KEY_W     = 4,
  parameter int unsigned TIME_20MS = 1_000_000,
  parameter int unsigned TIME_LONG = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_chan
    key_filter #(
      .TIME_20MS(TIME_20MS),
      .TIME_LONG(TIME_LONG)
    ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed self-checking bench for key_scan with TIME_20MS=5, TIME_LONG=20.
// Expected pulse edges are hand-derived: press/release appear after edge e0+7.
module tb_key_scan;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int checks;
  int failures;

  key_scan #(
    .KEY_W    (4),
    .TIME_20MS(5),
    .TIME_LONG(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    key_in = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d got=%h want=0000", k,
                 {key_state, key_press, key_release, key_long});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      checks++;
      if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
        failures++;
        $display("[TB] FAIL idle_outputs cycle %0d got=%h want=0000", k,
                 {key_state, key_press, key_release, key_long});
      end
    end
  endtask

  task automatic test_press_release();
    logic [3:0] exp_long;
    key_in[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL press0 k=%0d got=%b want=%b", k, key_press,
                 (k == 8) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (key_state !== ((k >= 8) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL state0_down k=%0d got=%b", k, key_state);
      end
      checks++;
      if (key_release !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL release0_early k=%0d got=%b want=0000", k, key_release);
      end
`ifdef KEY_LONG_PRESS_EN
      exp_long = (k == 27) ? 4'b0001 : 4'b0000;
`else
      exp_long = 4'b0000;
`endif
      checks++;
      if (key_long !== exp_long) begin
        failures++;
        $display("[TB] FAIL long0 k=%0d got=%b want=%b", k, key_long, exp_long);
      end
    end
    key_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (key_release !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL release0 k=%0d got=%b want=%b", k, key_release,
                 (k == 8) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (key_state !== ((k < 8) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL state0_up k=%0d got=%b", k, key_state);
      end
      checks++;
      if (key_press !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL press0_late k=%0d got=%b want=0000", k, key_press);
      end
    end
  endtask

  task automatic test_bounce();
    int lens [4] = '{3, 2, 3, 1};
    for (int s = 0; s < 4; s++) begin
      key_in[1] = s[0];
      for (int k = 0; k < lens[s]; k++) begin
        step();
        checks++;
        if ({key_press, key_release, key_state} !== 12'h0) begin
          failures++;
          $display("[TB] FAIL bounce_quiet seg=%0d got=%h want=000", s,
                   {key_press, key_release, key_state});
        end
      end
    end
    key_in[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 8) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL bounce_press k=%0d got=%b want=%b", k, key_press,
                 (k == 8) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (key_release !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bounce_release k=%0d got=%b want=0000", k, key_release);
      end
    end
    key_in[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (key_release !== ((k == 8) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL release1 k=%0d got=%b want=%b", k, key_release,
                 (k == 8) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_short_glitch();
    key_in[2] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == 4) key_in[2] = 1'b1;
      step();
      checks++;
      if ({key_press, key_release, key_state} !== 12'h0) begin
        failures++;
        $display("[TB] FAIL short_glitch k=%0d got=%h want=000", k,
                 {key_press, key_release, key_state});
      end
    end
  endtask

  task automatic test_multi_channel();
    key_in = 4'b0110;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 8) ? 4'b1001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL multi_press k=%0d got=%b want=%b", k, key_press,
                 (k == 8) ? 4'b1001 : 4'b0000);
      end
    end
    key_in = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (key_release !== ((k == 8) ? 4'b1001 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL multi_release k=%0d got=%b want=%b", k, key_release,
                 (k == 8) ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    key_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (key_state !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL held_state got=%b want=0010", key_state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%h want=0000",
               {key_state, key_press, key_release, key_long});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 8) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("[TB] FAIL repress k=%0d got=%b want=%b", k, key_press,
                 (k == 8) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (key_release !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_release k=%0d got=%b want=0000", k, key_release);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    key_in   = 4'hF;
    test_reset();
    test_press_release();
    test_bounce();
    test_short_glitch();
    test_multi_channel();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
